// File: rtl/host_cmd_uart_tx.sv
// Host-side command serializer: expands one command into its byte sequence
// and sends each byte as a UART frame (start, 8 data LSB first, optional parity, stop).
module host_cmd_uart_tx #(
    parameter int GAP_BITS = 1,
    parameter int DIV_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_TYPE,
    input  logic [3:0]       CMD_ADDR,
    input  logic [7:0]       CMD_D0,
    input  logic [7:0]       CMD_D1,
    input  logic [3:0]       CMD_FUN,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic [DIV_W-1:0] BAUD_DIV,
    output logic             TX_LINE,
    output logic             BUSY,
    output logic             DONE
);

    localparam int GAP_CW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_m1;
    logic [2:0]        bit_idx;
    logic [1:0]        byte_idx;
    logic [GAP_CW-1:0] gap_cnt;
    logic [7:0]        shreg;
    logic [1:0]        type_r;
    logic [3:0]        addr_r;
    logic [7:0]        d0_r;
    logic [7:0]        d1_r;
    logic [3:0]        fun_r;
    logic              par_en_r;
    logic              par_typ_r;
    logic              done_r;

    logic              tick;
    logic              accept;
    logic              last_byte;
    logic [1:0]        last_idx;
    logic [7:0]        cur_byte;

    assign tick   = (bit_cnt == div_m1);
    assign accept = (state == IDLE) && CMD_VALID;

    // Byte currently being framed, selected from the latched command fields
    always_comb begin
        cur_byte = 8'h00;
        last_idx = 2'd1;
        case (type_r)
            2'd0: begin
                last_idx = 2'd2;
                case (byte_idx)
                    2'd0:    cur_byte = 8'hAA;
                    2'd1:    cur_byte = {4'h0, addr_r};
                    default: cur_byte = d0_r;
                endcase
            end
            2'd1: cur_byte = (byte_idx == 2'd0) ? 8'hBB : {4'h0, addr_r};
            2'd2: begin
                last_idx = 2'd3;
                case (byte_idx)
                    2'd0:    cur_byte = 8'hCC;
                    2'd1:    cur_byte = d0_r;
                    2'd2:    cur_byte = d1_r;
                    default: cur_byte = {4'h0, fun_r};
                endcase
            end
            default: cur_byte = (byte_idx == 2'd0) ? 8'hDD : {4'h0, fun_r};
        endcase
    end

    assign last_byte = (byte_idx == last_idx);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (CMD_VALID) state_n = START;
            START:   if (tick) state_n = DATA;
            DATA:    if (tick && bit_idx == 3'd7) state_n = par_en_r ? PARITY : STOP;
            PARITY:  if (tick) state_n = STOP;
            STOP: begin
                if (tick) begin
                    if (last_byte)          state_n = IDLE;
                    else if (GAP_BITS == 0) state_n = START;
                    else                    state_n = GAP;
                end
            end
            GAP:     if (tick && gap_cnt == GAP_LAST) state_n = START;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt   <= '0;
            div_m1    <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            type_r    <= '0;
            addr_r    <= '0;
            d0_r      <= '0;
            d1_r      <= '0;
            fun_r     <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state == STOP) && tick && last_byte;
            if (state == IDLE) begin
                bit_cnt <= '0;
                if (accept) begin
                    div_m1    <= (BAUD_DIV == '0) ? '0 : BAUD_DIV - DIV_W'(1);
                    type_r    <= CMD_TYPE;
                    addr_r    <= CMD_ADDR;
                    d0_r      <= CMD_D0;
                    d1_r      <= CMD_D1;
                    fun_r     <= CMD_FUN;
                    par_en_r  <= PAR_EN;
                    par_typ_r <= PAR_TYP;
                    byte_idx  <= '0;
                    bit_idx   <= '0;
                    gap_cnt   <= '0;
                end
            end else begin
                bit_cnt <= tick ? '0 : bit_cnt + DIV_W'(1);
                if (tick) begin
                    case (state)
                        START: begin
                            shreg   <= cur_byte;
                            bit_idx <= '0;
                        end
                        DATA: begin
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                        STOP: begin
                            if (!last_byte) begin
                                byte_idx <= byte_idx + 2'd1;
                                gap_cnt  <= '0;
                            end
                        end
                        GAP:     gap_cnt <= gap_cnt + GAP_CW'(1);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Outputs decode only registered state, so they change exactly on clock edges
    always_comb begin
        TX_LINE = 1'b1;
        case (state)
            START:   TX_LINE = 1'b0;
            DATA:    TX_LINE = shreg[0];
            PARITY:  TX_LINE = (^cur_byte) ^ par_typ_r;
            default: TX_LINE = 1'b1;
        endcase
    end

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign DONE      = done_r;

endmodule

// File: tb/tb_host_cmd_uart_tx.sv
// Bench for host_cmd_uart_tx: a per-cycle expected TX_LINE waveform is built from
// the command's byte list and frame rules, then compared against two DUT instances.
module tb_host_cmd_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic [1:0]  cmd_type = '0;
    logic [3:0]  cmd_addr = '0;
    logic [7:0]  cmd_d0 = '0, cmd_d1 = '0;
    logic [3:0]  cmd_fun = '0;
    logic        par_en = 1'b0, par_typ = 1'b0;
    logic [15:0] baud_div = 16'd1;
    logic        ready_a, tx_a, busy_a, done_a;
    logic        ready_b, tx_b, busy_b, done_b;

    int n_checks = 0;
    int n_pass = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    host_cmd_uart_tx #(.GAP_BITS(1), .DIV_W(16)) dut_a (
        .CLK(clk), .RST(rst_n), .CMD_VALID(valid_a), .CMD_READY(ready_a),
        .CMD_TYPE(cmd_type), .CMD_ADDR(cmd_addr), .CMD_D0(cmd_d0), .CMD_D1(cmd_d1),
        .CMD_FUN(cmd_fun), .PAR_EN(par_en), .PAR_TYP(par_typ), .BAUD_DIV(baud_div),
        .TX_LINE(tx_a), .BUSY(busy_a), .DONE(done_a)
    );

    host_cmd_uart_tx #(.GAP_BITS(0), .DIV_W(16)) dut_b (
        .CLK(clk), .RST(rst_n), .CMD_VALID(valid_b), .CMD_READY(ready_b),
        .CMD_TYPE(cmd_type), .CMD_ADDR(cmd_addr), .CMD_D0(cmd_d0), .CMD_D1(cmd_d1),
        .CMD_FUN(cmd_fun), .PAR_EN(par_en), .PAR_TYP(par_typ), .BAUD_DIV(baud_div),
        .TX_LINE(tx_b), .BUSY(busy_b), .DONE(done_b)
    );

    task automatic push_bit(input logic v, input int w);
        for (int r = 0; r < w; r++) exp_q.push_back(v);
    endtask

    // Reference waveform: one entry per clock cycle after acceptance
    task automatic build_model(input logic [1:0] typ, input logic [3:0] addr,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [3:0] fun, input bit pe, input bit pt,
                               input int div, input int gap);
        logic [7:0] bytes[$];
        logic [7:0] cur;
        int w;
        exp_q.delete();
        bytes.delete();
        case (typ)
            2'd0: begin bytes.push_back(8'hAA); bytes.push_back({4'h0, addr}); bytes.push_back(d0); end
            2'd1: begin bytes.push_back(8'hBB); bytes.push_back({4'h0, addr}); end
            2'd2: begin bytes.push_back(8'hCC); bytes.push_back(d0); bytes.push_back(d1);
                        bytes.push_back({4'h0, fun}); end
            default: begin bytes.push_back(8'hDD); bytes.push_back({4'h0, fun}); end
        endcase
        w = (div < 1) ? 1 : div;
        for (int i = 0; i < bytes.size(); i++) begin
            cur = bytes[i];
            push_bit(1'b0, w);
            for (int b = 0; b < 8; b++) push_bit(cur[b], w);
            if (pe) push_bit((^cur) ^ pt, w);
            push_bit(1'b1, w);
            if (i != bytes.size() - 1) push_bit(1'b1, gap * w);
        end
    endtask

    task automatic set_valid(input bit which, input logic v);
        if (which) valid_b = v;
        else valid_a = v;
    endtask

    task automatic drive_cmd(input bit which, input logic [1:0] typ, input logic [3:0] addr,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] fun,
                             input bit pe, input bit pt, input int div);
        build_model(typ, addr, d0, d1, fun, pe, pt, div, which ? 0 : 1);
        @(negedge clk);
        cmd_type = typ; cmd_addr = addr; cmd_d0 = d0; cmd_d1 = d1; cmd_fun = fun;
        par_en = pe; par_typ = pt; baud_div = 16'(div);
        set_valid(which, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Called just after the acceptance edge; walks the expected waveform cycle by cycle
    task automatic check_seq(input bit which, input string name, input bit keep_valid,
                             input bit disturb);
        int total, bad_tx, bad_st, first_k;
        logic o_tx, o_rdy, o_busy, o_done, first_obs;
        total = exp_q.size();
        bad_tx = 0; bad_st = 0; first_k = -1; first_obs = 1'b0;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (k == 0 && !keep_valid) set_valid(which, 1'b0);
            if (disturb && k == total / 3) begin
                set_valid(which, 1'b1);
                baud_div = 16'd1; cmd_d0 = ~cmd_d0; cmd_type = ~cmd_type; par_en = ~par_en;
            end
            if (disturb && k == total / 3 + 2) set_valid(which, 1'b0);
            o_tx   = which ? tx_b : tx_a;
            o_rdy  = which ? ready_b : ready_a;
            o_busy = which ? busy_b : busy_a;
            o_done = which ? done_b : done_a;
            if (o_tx !== exp_q[k]) begin
                if (first_k < 0) begin first_k = k; first_obs = o_tx; end
                bad_tx++;
            end
            if (o_busy !== 1'b1 || o_rdy !== 1'b0 || o_done !== 1'b0) bad_st++;
        end
        n_checks++;
        if (bad_tx != 0)
            $display("FAIL %s tx_seq: %0d of %0d cycles wrong, first at cycle %0d got %b need %b",
                     name, bad_tx, total, first_k, first_obs, exp_q[first_k]);
        else n_pass++;
        n_checks++;
        if (bad_st != 0)
            $display("FAIL %s busy_status: %0d cycles not busy=1 ready=0 done=0, need 0", name, bad_st);
        else n_pass++;
        @(negedge clk);
        o_tx   = which ? tx_b : tx_a;
        o_rdy  = which ? ready_b : ready_a;
        o_busy = which ? busy_b : busy_a;
        o_done = which ? done_b : done_a;
        n_checks++;
        if (o_done !== 1'b1)
            $display("FAIL %s done_at_%0d: got %b need 1", name, total, o_done);
        else n_pass++;
        n_checks++;
        if ({o_rdy, o_busy, o_tx} !== 3'b101)
            $display("FAIL %s idle_in_done_cycle: ready/busy/tx got %b%b%b need 101",
                     name, o_rdy, o_busy, o_tx);
        else n_pass++;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({tx_a, ready_a, busy_a, done_a, tx_b, ready_b, busy_b, done_b} !== 8'b1100_1100)
            $display("FAIL reset_state: got %b%b%b%b_%b%b%b%b need 1100_1100",
                     tx_a, ready_a, busy_a, done_a, tx_b, ready_b, busy_b, done_b);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rf_write();
        drive_cmd(1'b0, 2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, 1'b1, 1'b0, 4);
        check_seq(1'b0, "rf_write", 1'b0, 1'b0);
    endtask

    task automatic test_rf_read_odd();
        drive_cmd(1'b0, 2'd1, 4'hB, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 4);
        check_seq(1'b0, "rf_read_odd", 1'b0, 1'b0);
    endtask

    task automatic test_alu_nogap();
        drive_cmd(1'b1, 2'd2, 4'h0, 8'h12, 8'h34, 4'h1, 1'b0, 1'b0, 1);
        check_seq(1'b1, "alu_nogap", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive_cmd(1'b0, 2'd3, 4'h0, 8'h00, 8'h00, 4'h2, 1'b1, 1'b0, 2);
        cmd_fun = 4'h5;
        check_seq(1'b0, "b2b_first", 1'b1, 1'b0);
        build_model(2'd3, 4'h0, 8'h00, 8'h00, 4'h5, 1'b1, 1'b0, 2, 1);
        @(posedge clk);
        #1;
        check_seq(1'b0, "b2b_second", 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        drive_cmd(1'b0, 2'd0, 4'h9, 8'hC3, 8'h00, 4'h0, 1'b1, 1'b0, 3);
        check_seq(1'b0, "busy_ignore", 1'b0, 1'b1);
    endtask

    task automatic test_midframe_reset();
        drive_cmd(1'b0, 2'd0, 4'h6, 8'hF0, 8'h00, 4'h0, 1'b0, 1'b0, 2);
        for (int k = 0; k <= 28; k++) begin
            @(negedge clk);
            if (k == 0) valid_a = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100)
            $display("FAIL midframe_reset: tx/ready/busy/done got %b%b%b%b need 1100",
                     tx_a, ready_a, busy_a, done_a);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int bad = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
            end
            n_checks++;
            if (bad != 0) $display("FAIL post_reset_idle: %0d cycles active, need 0", bad);
            else n_pass++;
        end
        drive_cmd(1'b0, 2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 2);
        check_seq(1'b0, "after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            bit which;
            which = 1'($urandom_range(0, 1));
            drive_cmd(which, 2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom),
                      4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 5)));
            check_seq(which, $sformatf("random_%0d", i), 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_rf_write();
        test_rf_read_odd();
        test_alu_nogap();
        test_back_to_back();
        test_busy_ignore();
        test_midframe_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
